// File: rtl/coin_acceptor.sv
// Coin acceptor front end for the vending FSM.
// Two slot sensors are synchronized and debounced. Each debounced rising edge
// is a coin event: it is either queued in a 4-deep FIFO or refused with a
// reject pulse. Queued coins are replayed to the vending FSM as one-cycle
// {i,j} strobes, with a fixed number of idle cycles after every strobe.
module coin_acceptor #(
  parameter int DEBOUNCE = 4,
  parameter int GAP      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin1_raw,
  input  logic       coin2_raw,
  input  logic       accept_en,
  output logic       i,
  output logic       j,
  output logic       reject,
  output logic       jam,
  output logic [2:0] fifo_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE);
  localparam logic [2:0] GAP_LAST  = 3'(GAP - 1);

  // Channel 0 is the 1 Rs slot, channel 1 the 2 Rs slot.
  logic [1:0]      raw_s;
  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;
  logic [1:0]      deb_q, deb_d;
  logic [1:0]      deb_prev_q, deb_prev_d;
  logic [1:0][3:0] dcnt_q, dcnt_d;
  logic [1:0]      evt_q, evt_d;

  logic [3:0]      mem_q, mem_d;
  logic [1:0]      wr_ptr_q, wr_ptr_d;
  logic [1:0]      rd_ptr_q, rd_ptr_d;
  logic [2:0]      cnt_q, cnt_d;

  logic [1:0]      state_q, state_d;
  logic [2:0]      gap_cnt_q, gap_cnt_d;
  logic            i_q, i_d;
  logic            j_q, j_d;
  logic            reject_q, reject_d;
  logic            jam_q, jam_d;

  logic            push_s;
  logic            push_data_s;
  logic            pop_s;
  logic            pop_data_s;
  logic            full_s;
  logic            empty_s;

  assign raw_s       = {coin2_raw, coin1_raw};
  assign full_s      = (cnt_q == 3'd4);
  assign empty_s     = (cnt_q == 3'd0);
  assign pop_data_s  = mem_q[rd_ptr_q];
  assign push_data_s = evt_q[1];

  // Synchronize, debounce and detect rising edges of the debounced levels.
  always_comb begin
    sync1_d    = raw_s;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    dcnt_d     = dcnt_q;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if ((dcnt_q[k] + 4'd1) == DEB_LIMIT) begin
          deb_d[k]  = ~deb_q[k];
          dcnt_d[k] = 4'd0;
        end else begin
          deb_d[k]  = deb_q[k];
          dcnt_d[k] = dcnt_q[k] + 4'd1;
        end
      end else begin
        deb_d[k]  = deb_q[k];
        dcnt_d[k] = 4'd0;
      end
    end
    evt_d = deb_q & ~deb_prev_q;
  end

  // Decide whether a coin event is queued, rejected or flagged as a jam.
  always_comb begin
    push_s   = 1'b0;
    reject_d = 1'b0;
    jam_d    = 1'b0;
    case (evt_q)
      2'b11: begin
        jam_d    = 1'b1;
        reject_d = 1'b1;
      end
      2'b01, 2'b10: begin
        // Fullness is judged on the occupancy before any same-cycle pop.
        if (!accept_en || full_s) begin
          reject_d = 1'b1;
        end else begin
          push_s = 1'b1;
        end
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  // Output sequencer: pop a coin, strobe it for one cycle, then idle GAP cycles.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    pop_s     = 1'b0;
    i_d       = 1'b0;
    j_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_d = ST_EMIT;
          i_d     = 1'b1;
          j_d     = pop_data_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        state_d   = ST_GAP;
        gap_cnt_d = 3'd0;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (!empty_s) begin
            pop_s   = 1'b1;
            state_d = ST_EMIT;
            i_d     = 1'b1;
            j_d     = pop_data_s;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO storage, wrap-around pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = push_data_s;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      deb_q      <= 2'b00;
      deb_prev_q <= 2'b00;
      dcnt_q     <= '0;
      evt_q      <= 2'b00;
      mem_q      <= 4'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      cnt_q      <= 3'd0;
      state_q    <= ST_IDLE;
      gap_cnt_q  <= 3'd0;
      i_q        <= 1'b0;
      j_q        <= 1'b0;
      reject_q   <= 1'b0;
      jam_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      dcnt_q     <= dcnt_d;
      evt_q      <= evt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      i_q        <= i_d;
      j_q        <= j_d;
      reject_q   <= reject_d;
      jam_q      <= jam_d;
    end
  end

  assign i        = i_q;
  assign j        = j_q;
  assign reject   = reject_q;
  assign jam      = jam_q;
  assign fifo_cnt = cnt_q;

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive cycles a synchronized coin input must hold a new level before the debounced level changes (range 1..15).
REQ-002 Parameter GAP, default 1: idle ({i,j}=00) cycles inserted after every emitted coin pulse (range 1..7).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 coin1_raw  input  1  asynchronous 1 Rs slot sensor level, high while a coin passes.
REQ-006 coin2_raw  input  1  asynchronous 2 Rs slot sensor level, high while a coin passes.
REQ-007 accept_en  input  1  high = coins accepted; low = every detected coin rejected.
REQ-008 i  output  1  coin-valid strobe to the vending FSM, registered.
REQ-009 j  output  1  denomination bit to the vending FSM (0 = 1 Rs, 1 = 2 Rs when i=1), registered.
REQ-010 reject  output  1  one-cycle pulse: detected coin not queued (return-flap command).
REQ-011 jam  output  1  one-cycle pulse: both slots detected in the same cycle.
REQ-012 fifo_cnt  output  3  current queue occupancy, 0..4.

Function
REQ-013 Each raw input SHALL pass a 2-flop synchronizer before any other use.
REQ-014 Per channel, a debounce counter SHALL increment while the synchronized level differs from the debounced level, clear whenever they agree, and toggle the debounced level on reaching DEBOUNCE.
REQ-015 A coin event SHALL be a 0->1 transition of a debounced level; 1->0 transitions generate nothing.
REQ-016 Both events in the same cycle: jam=1 and reject=1 for one cycle, nothing queued.
REQ-017 Single event with accept_en=0: reject=1 for one cycle, nothing queued.
REQ-018 Single event with accept_en=1 and queue full (4 entries, evaluated before any same-cycle pop): reject=1 for one cycle, nothing queued.
REQ-019 Otherwise the event SHALL be pushed (entry 0 = 1 Rs, 1 = 2 Rs) into a 4-deep FIFO with 2-bit wrap-around pointers; a same-cycle push and pop SHALL leave fifo_cnt unchanged.
REQ-020 Output FSM states: IDLE, EMIT, GAP.
REQ-021 IDLE: {i,j}=00; if FIFO non-empty, pop and go to EMIT.
REQ-022 EMIT: lasts exactly one cycle, {i,j}=10 for 1 Rs, 11 for 2 Rs; then GAP.
REQ-023 GAP: {i,j}=00 for GAP cycles; in the last GAP cycle, if FIFO non-empty, pop and go to EMIT, else IDLE.
REQ-024 Back-to-back queued coins SHALL be separated by exactly GAP cycles of {i,j}=00.
REQ-025 {i,j}=01 SHALL never be driven.
REQ-026 Latency, FIFO empty and FSM IDLE: i rises exactly DEBOUNCE+4 cycles after the first clk edge sampling coin_raw=1 (2 sync + DEBOUNCE + push + emit).
REQ-027 A raw pulse shorter than DEBOUNCE synchronized cycles SHALL produce no event, no reject.
REQ-028 A coin held high indefinitely SHALL produce exactly one event.

Reset
REQ-029 While rst=0 at a clk edge: i=0, j=0, reject=0, jam=0, fifo_cnt=0, FIFO emptied, pointers 0, FSM=IDLE, synchronizers, debounced levels and counters 0.
REQ-030 Reset mid-emit or mid-queue SHALL discard all queued coins without any further i pulse.
REQ-031 Coin inputs held high through reset release SHALL generate an event after DEBOUNCE+3 cycles (debounced level restarts at 0).

Verification
REQ-032 DEBOUNCE=4, GAP=1: coin1_raw high 10 cycles, accept_en=1 -> {i,j}=10 for one cycle, 8 cycles after first sample; fifo_cnt returns to 0.
REQ-033 coin2_raw glitch high 3 cycles -> no i, no reject, fifo_cnt stays 0.
REQ-034 Five 1 Rs coins debounced while FSM stalled in EMIT/GAP -> four queued, fifth gives reject pulse, fifo_cnt peaks at 4, four i pulses each spaced by one 00 cycle.
REQ-035 coin1_raw and coin2_raw rise together -> jam=1 and reject=1 for one cycle, no i.
REQ-036 accept_en=0, coin2 inserted -> reject pulse only; rst=0 asserted during queued emission -> all outputs 0 next cycle, no remaining pulses.
